// File: rtl/uart_sel_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package    : uart_sel_pkg
// Description: Shared types and constants for the UART port-select sequencer.
//              Holds the FSM state type, the select encodings and a helper
//              that sizes the bounded counters.
// Revision   : 1.0  initial release
// ============================================================================
package uart_sel_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    SWITCH = 2'd2,
    GUARD  = 2'd3
  } sel_state_t;

  // Routing select encodings: 1 routes the PC to the ESP master, 0 to the ESP sim.
  localparam logic SEL_MASTER = 1'b1;
  localparam logic SEL_SIM    = 1'b0;

  // Width for a counter that must hold values up to p. One spare bit keeps
  // the terminal compare value representable even for power-of-two p.
  function automatic int cnt_width(input int p);
    return $clog2((p < 2) ? 2 : p) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sel_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface  : uart_sel_ctrl_if
// Description: Board-side bundle of the UART port-select sequencer.
//   btn_select    raw front-panel pushbutton, active-high, asynchronous
//   rx_pc         PC->FPGA UART line, idle high, asynchronous
//   rx_esp_master ESP master->FPGA UART line, idle high, asynchronous
//   rx_esp_sim    ESP sim->FPGA UART line, idle high, asynchronous
//   select        routing select to the selector datapath
//   busy          switch sequence in progress
//   forced        one-cycle pulse on a timeout-forced switch
//   master : pin/board side (drives button and lines, observes results)
//   slave  : the sequencer itself
// Revision   : 1.0  initial release
// ============================================================================
interface uart_sel_ctrl_if;

  logic btn_select;
  logic rx_pc;
  logic rx_esp_master;
  logic rx_esp_sim;
  logic select;
  logic busy;
  logic forced;

  modport master (
    output btn_select, rx_pc, rx_esp_master, rx_esp_sim,
    input  select, busy, forced
  );

  modport slave (
    input  btn_select, rx_pc, rx_esp_master, rx_esp_sim,
    output select, busy, forced
  );

endinterface
`default_nettype wire

// File: rtl/uart_sel_ctrl_debounce.sv
`default_nettype none
// ============================================================================
// Module     : sel_debounce
// Description: Pushbutton conditioner. 2-FF synchroniser, stability counter,
//              debounced level and a one-cycle request on each debounced press.
// Ports      :
//   clk    in  system clock
//   reset  in  asynchronous active-low reset
//   i_btn  in  raw pushbutton, active-high, asynchronous
//   o_req  out one-cycle pulse on a debounced 0->1 transition
// Revision   : 1.0  initial release
// ============================================================================
module sel_debounce
  import uart_sel_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic i_btn,
  output logic      o_req
);

  localparam int                c_CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic               r_meta;
  logic               r_sync;
  logic               r_level;
  logic               r_req;
  logic [c_CNT_W-1:0] r_cnt;

  // The counter only runs while the synchronised button disagrees with the
  // accepted level; any cycle of agreement (a bounce back) restarts it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_meta  <= 1'b0;
      r_sync  <= 1'b0;
      r_level <= 1'b0;
      r_req   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_meta <= i_btn;
      r_sync <= r_meta;
      r_req  <= 1'b0;
      if (r_sync == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == c_LAST) begin
        r_cnt   <= '0;
        r_level <= r_sync;
        // Only a press raises a request; a release is silent.
        r_req   <= r_sync;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_req = r_req;

endmodule
`default_nettype wire

// File: rtl/uart_sel_ctrl.sv
`default_nettype none
// ============================================================================
// Module     : uart_sel_ctrl
// Description: UART port-select sequencer. Turns a front-panel button into a
//              glitch-free routing select, deferring each switch until all
//              three UART lines have been idle for a full frame (or a drain
//              timeout expires), then holding off new requests for a guard
//              period.
// Ports      :
//   clk    in  system clock, single domain
//   reset  in  asynchronous active-low reset
//   bus    slave modport of uart_sel_ctrl_if (button, UART lines in;
//          select, busy, forced out)
// Revision   : 1.0  initial release
// ============================================================================
module uart_sel_ctrl
  import uart_sel_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = 500000,
  parameter int   IDLE_CYCLES     = 4340,
  parameter int   TIMEOUT_CYCLES  = 5000000,
  parameter int   GUARD_CYCLES    = 4340,
  parameter logic SEL_RESET       = SEL_MASTER
) (
  input  wire logic      clk,
  input  wire logic      reset,
  uart_sel_ctrl_if.slave bus
);

  localparam int                   c_IDLE_W  = cnt_width(IDLE_CYCLES);
  localparam logic [c_IDLE_W-1:0]  c_IDLE_MAX = c_IDLE_W'(IDLE_CYCLES);
  localparam int                   c_TO_W    = cnt_width(TIMEOUT_CYCLES);
  localparam logic [c_TO_W-1:0]    c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);
  localparam int                   c_GD_W    = cnt_width(GUARD_CYCLES);
  localparam logic [c_GD_W-1:0]    c_GD_LAST = c_GD_W'(GUARD_CYCLES - 1);

  logic                w_req;
  logic [2:0]          w_rx_raw;
  logic                w_all_idle;
  logic                w_line_idle;

  logic [2:0]          r_rx_meta;
  logic [2:0]          r_rx_sync;
  logic [c_IDLE_W-1:0] r_idle_cnt;

  sel_state_t          r_state;
  logic [c_TO_W-1:0]   r_to_cnt;
  logic [c_GD_W-1:0]   r_gd_cnt;
  logic                r_force_flag;
  logic                r_select;
  logic                r_busy;
  logic                r_forced;

  sel_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk   (clk),
    .reset (reset),
    .i_btn (bus.btn_select),
    .o_req (w_req)
  );

  assign w_rx_raw = {bus.rx_pc, bus.rx_esp_master, bus.rx_esp_sim};

  // Line synchronisers come out of reset at the idle level so a reset
  // release never looks like a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_meta <= 3'b111;
      r_rx_sync <= 3'b111;
    end else begin
      r_rx_meta <= w_rx_raw;
      r_rx_sync <= r_rx_meta;
    end
  end

  assign w_all_idle = &r_rx_sync;

  // Counts consecutive all-idle cycles; saturating keeps line_idle asserted
  // for as long as the lines stay quiet.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idle_cnt <= '0;
    end else if (!w_all_idle) begin
      r_idle_cnt <= '0;
    end else if (r_idle_cnt != c_IDLE_MAX) begin
      r_idle_cnt <= r_idle_cnt + 1'b1;
    end
  end

  assign w_line_idle = (r_idle_cnt == c_IDLE_MAX);

  // Sequencer. busy is registered alongside the state so it tracks
  // (state != IDLE) with no combinational path to the output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_to_cnt     <= '0;
      r_gd_cnt     <= '0;
      r_force_flag <= 1'b0;
      r_select     <= SEL_RESET;
      r_busy       <= 1'b0;
      r_forced     <= 1'b0;
    end else begin
      r_forced <= 1'b0;
      case (r_state)
        IDLE: begin
          r_to_cnt <= '0;
          if (w_req) begin
            r_state      <= DRAIN;
            r_busy       <= 1'b1;
            r_force_flag <= 1'b0;
          end
        end
        DRAIN: begin
          // A real idle window wins over a coincident timeout.
          if (w_line_idle) begin
            r_state      <= SWITCH;
            r_force_flag <= 1'b0;
          end else if (r_to_cnt == c_TO_LAST) begin
            r_state      <= SWITCH;
            r_force_flag <= 1'b1;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        SWITCH: begin
          r_state  <= GUARD;
          r_select <= ~r_select;
          r_forced <= r_force_flag;
          r_gd_cnt <= '0;
        end
        GUARD: begin
          if (r_gd_cnt == c_GD_LAST) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_gd_cnt <= r_gd_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.select = r_select;
  assign bus.busy   = r_busy;
  assign bus.forced = r_forced;

endmodule
`default_nettype wire

// File: tb/tb_uart_sel_ctrl.sv
`default_nettype none
// ============================================================================
// Module     : tb_uart_sel_ctrl
// Description: Testbench for uart_sel_ctrl. A timestamp-based reference model
//              predicts every change of {select, busy, forced}; a monitor
//              matches the DUT's output changes against those predictions.
// Revision   : 1.0  initial release
// ============================================================================
module tb_uart_sel_ctrl;

  localparam int DEB = 8;
  localparam int IDL = 20;
  localparam int TMO = 100;
  localparam int GRD = 10;
  localparam logic [2:0] c_RST_VEC = 3'b100;  // {select, busy, forced}

  logic clk   = 1'b0;
  logic reset = 1'b0;

  uart_sel_ctrl_if bus ();

  uart_sel_ctrl #(
    .DEBOUNCE_CYCLES (DEB),
    .IDLE_CYCLES     (IDL),
    .TIMEOUT_CYCLES  (TMO),
    .GUARD_CYCLES    (GRD),
    .SEL_RESET       (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef struct {
    int         cyc;
    logic [2:0] vec;
  } ev_t;
  ev_t q[$];

  // ---------------- reference model ----------------
  logic hist_b[$];
  logic hist_l[$];
  logic m_level, m_req, m_drain, m_fflag;
  int   m_run, m_idle_run, m_dstart, m_sw;
  logic [2:0] m_vec;
  logic b_s, l_s, line_idle, req_now, n_sel, n_busy, n_frc;
  logic [2:0] n_vec;

  always @(posedge clk) begin
    cyc++;
    if (!reset) begin
      hist_b.delete();
      hist_l.delete();
      m_level = 1'b0; m_req = 1'b0; m_drain = 1'b0; m_fflag = 1'b0;
      m_run = 0; m_idle_run = 0; m_dstart = 0; m_sw = -100000;
      m_vec = c_RST_VEC;
      q.delete();
    end else begin
      // Inputs reach the decision logic two cycles late.
      hist_b.push_back(bus.btn_select);
      hist_l.push_back(bus.rx_pc & bus.rx_esp_master & bus.rx_esp_sim);
      if (hist_b.size() > 3) begin
        void'(hist_b.pop_front());
        void'(hist_l.pop_front());
      end
      b_s = (hist_b.size() >= 3) ? hist_b[0] : 1'b0;
      l_s = (hist_l.size() >= 3) ? hist_l[0] : 1'b1;

      line_idle = (m_idle_run >= IDL);
      req_now   = m_req;
      m_idle_run = l_s ? m_idle_run + 1 : 0;

      m_req = 1'b0;
      if (b_s != m_level) begin
        m_run++;
        if (m_run == DEB) begin
          m_level = b_s;
          m_run   = 0;
          m_req   = b_s;
        end
      end else begin
        m_run = 0;
      end

      if (!m_vec[1] && req_now) begin
        m_drain  = 1'b1;
        m_dstart = cyc;
      end else if (m_drain) begin
        if (line_idle) begin
          m_drain = 1'b0; m_sw = cyc; m_fflag = 1'b0;
        end else if (cyc - m_dstart == TMO) begin
          m_drain = 1'b0; m_sw = cyc; m_fflag = 1'b1;
        end
      end

      n_busy = m_drain || (cyc >= m_sw && cyc <= m_sw + GRD);
      n_sel  = (cyc == m_sw + 1) ? ~m_vec[2] : m_vec[2];
      n_frc  = (cyc == m_sw + 1) && m_fflag;
      n_vec  = {n_sel, n_busy, n_frc};
      if (n_vec != m_vec) begin
        q.push_back('{cyc: cyc, vec: n_vec});
        m_vec = n_vec;
      end
    end
  end

  // ---------------- monitor ----------------
  logic [2:0] last_vec = c_RST_VEC;
  logic [2:0] cur_vec;
  ev_t        e;

  always @(negedge clk) begin
    if (!reset) begin
      last_vec = c_RST_VEC;
    end else begin
      cur_vec = {bus.select, bus.busy, bus.forced};
      if (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        n_cmp++; n_bad++;
        $display("FAIL missed_change: outputs stayed %b, want %b at cycle %0d", last_vec, e.vec, e.cyc);
      end
      if (cur_vec != last_vec) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_change: cycle %0d sel/busy/forced got %b, want %b", cyc, cur_vec, last_vec);
        end else begin
          e = q.pop_front();
          if (e.cyc != cyc || e.vec != cur_vec) begin
            n_bad++;
            $display("FAIL output_change: got %b at cycle %0d, want %b at cycle %0d", cur_vec, cyc, e.vec, e.cyc);
          end
        end
        last_vec = cur_vec;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_busy(input int limit);
    int k;
    k = 0;
    while (!bus.busy && k < limit) begin
      @(negedge clk);
      k++;
    end
    if (!bus.busy) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_busy: busy got 0 after %0d cycles, want 1", limit);
    end
  endtask

  task automatic lines_idle();
    bus.rx_pc = 1'b1; bus.rx_esp_master = 1'b1; bus.rx_esp_sim = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int r, plen, gap, mode;
    bus.btn_select = 1'b0;
    lines_idle();
    step(4);
    @(posedge clk); #2 reset = 1'b1;
    step(1);
    chk("reset_select", int'(bus.select), 1);
    chk("reset_busy",   int'(bus.busy),   0);
    chk("reset_forced", int'(bus.forced), 0);

    // Clean press on idle lines.
    step(30);
    bus.btn_select = 1'b1; step(20);
    bus.btn_select = 1'b0; step(40);

    // Bounce shorter than the debounce window.
    for (int i = 0; i < 8; i++) begin
      bus.btn_select = 1'b1; step(3);
      bus.btn_select = 1'b0; step(2);
    end
    step(30);

    // Press while rx_pc carries a frame.
    for (int i = 0; i < 60; i++) begin
      bus.rx_pc      = ((i / 5) % 2 == 0) ? 1'b0 : 1'b1;
      bus.btn_select = (i >= 5 && i < 25);
      step(1);
    end
    bus.rx_pc = 1'b1;
    step(60);

    // Stuck line forces a timeout switch; a second press lands in GUARD.
    bus.rx_esp_sim = 1'b0;
    bus.btn_select = 1'b1;
    wait_busy(40);
    step(4);
    bus.btn_select = 1'b0;
    r = $urandom_range(0, 3);
    step(89 + r);
    bus.btn_select = 1'b1; step(15);
    bus.btn_select = 1'b0;
    bus.rx_esp_sim = 1'b1;
    step(60);

    // Reset in the middle of DRAIN.
    bus.rx_pc      = 1'b0;
    bus.btn_select = 1'b1;
    wait_busy(40);
    step($urandom_range(1, 20));
    @(posedge clk); #2 reset = 1'b0;
    #1;
    chk("midreset_select", int'(bus.select), 1);
    chk("midreset_busy",   int'(bus.busy),   0);
    chk("midreset_forced", int'(bus.forced), 0);
    bus.btn_select = 1'b0;
    bus.rx_pc      = 1'b1;
    step(3);
    @(posedge clk); #2 reset = 1'b1;
    step(60);

    // Randomised presses, bounces and line activity.
    for (int it = 0; it < 30; it++) begin
      plen = $urandom_range(2, 25);
      gap  = $urandom_range(5, 40);
      mode = $urandom_range(0, 3);
      if (mode == 3) gap = gap + 90;
      for (int i = 0; i < plen + gap; i++) begin
        bus.btn_select = (i < plen);
        case (mode)
          1: bus.rx_pc         = ($urandom_range(0, 7) != 0);
          2: bus.rx_esp_master = ((i % 9) != 4);
          3: bus.rx_esp_sim    = 1'b0;
          default: lines_idle();
        endcase
        step(1);
      end
      lines_idle();
    end

    bus.btn_select = 1'b0;
    lines_idle();
    step(150);
    chk("scoreboard_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
